// File: rtl/mlp_batch_evaluator_pkg.sv
// Shared state encoding and width helpers for the MLP batch evaluator.
package mlp_eval_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      START,
      WAIT,
      SCORE,
      REPORT
   } state_t;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mlp_batch_evaluator_if.sv
// Labelled-sample stream between a sample source and the evaluator.
interface mlp_batch_evaluator_if #(
   parameter int NUM_FEATURES  = 4,
   parameter int FP_TOTAL_BITS = 16,
   parameter int LABEL_W       = 2
) ();
   logic                                  s_valid;
   logic                                  s_ready;
   logic [NUM_FEATURES*FP_TOTAL_BITS-1:0] s_x;
   logic [LABEL_W-1:0]                    s_label;
   logic                                  s_last;

   modport master (output s_valid, s_x, s_label, s_last, input s_ready);
   modport slave  (input s_valid, s_x, s_label, s_last, output s_ready);
endinterface

// File: rtl/mlp_batch_evaluator_argmax.sv
// Sequential signed arg-max: one strict compare per step, ties keep the lower index.
module mlp_argmax_seq #(
   parameter int NUM_CLASSES   = 3,
   parameter int FP_TOTAL_BITS = 16,
   parameter int LABEL_W       = 2
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 i_load,
   input  logic                                 i_step,
   input  logic [NUM_CLASSES*FP_TOTAL_BITS-1:0] i_scores,
   output logic                                 o_busy,
   output logic                                 o_last,
   output logic [LABEL_W-1:0]                   o_best
);
   localparam logic [LABEL_W-1:0] LAST_IDX = LABEL_W'(NUM_CLASSES - 1);

   logic [NUM_CLASSES*FP_TOTAL_BITS-1:0] r_scores;
   logic signed [FP_TOTAL_BITS-1:0]      r_best_val;
   logic [LABEL_W-1:0]                   r_best_idx;
   logic [LABEL_W-1:0]                   r_idx;
   logic                                 r_busy;
   logic signed [FP_TOTAL_BITS-1:0]      w_cand;
   logic                                 w_gt;

   assign w_cand = r_scores[r_idx*FP_TOTAL_BITS +: FP_TOTAL_BITS];
   assign w_gt   = (w_cand > r_best_val);
   // o_best already includes the compare being made this cycle
   assign o_best = w_gt ? r_idx : r_best_idx;
   assign o_last = (r_idx == LAST_IDX);
   assign o_busy = r_busy;

   // Control: candidate index walks 1..NUM_CLASSES-1, busy until the last compare
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_idx  <= '0;
      end else if (i_load) begin
         r_busy <= 1'b1;
         r_idx  <= LABEL_W'(1);
      end else if (i_step && r_busy) begin
         if (o_last) r_busy <= 1'b0;
         else        r_idx  <= r_idx + 1'b1;
      end
   end

   // Data: captured scores and running winner, seeded with class 0
   always_ff @(posedge clk) begin
      if (i_load) begin
         r_scores   <= i_scores;
         r_best_val <= i_scores[FP_TOTAL_BITS-1:0];
         r_best_idx <= '0;
      end else if (i_step && r_busy) begin
         if (w_gt) r_best_val <= w_cand;
         r_best_idx <= o_best;
      end
   end
endmodule

// File: rtl/mlp_batch_evaluator.sv
// Scores labelled samples through one MLP instance and keeps per-batch accuracy counters.
module mlp_batch_evaluator
   import mlp_eval_pkg::*;
#(
   parameter int NUM_FEATURES   = 4,
   parameter int NUM_CLASSES    = 3,
   parameter int FP_TOTAL_BITS  = 16,
   parameter int BATCH_SIZE     = 30,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int LABEL_W        = clog2_min1(NUM_CLASSES),
   parameter int CNT_W          = clog2_min1(BATCH_SIZE + 1)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  batch_clear,
   mlp_batch_evaluator_if.slave                  s_if,
   output logic                                  mlp_clear,
   output logic                                  mlp_start,
   output logic [NUM_FEATURES*FP_TOTAL_BITS-1:0] mlp_x,
   input  logic                                  mlp_done,
   input  logic [NUM_CLASSES*FP_TOTAL_BITS-1:0]  mlp_out,
   output logic                                  pred_valid,
   output logic [LABEL_W-1:0]                    pred_class,
   output logic                                  pred_correct,
   output logic                                  pred_timeout,
   output logic [CNT_W-1:0]                      sample_count,
   output logic [CNT_W-1:0]                      correct_count,
   output logic                                  batch_done
);
   localparam int                TMR_W    = clog2_min1(TIMEOUT_CYCLES + 1);
   localparam bit                TMO_EN   = (TIMEOUT_CYCLES > 0);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t                                r_state, w_state_nxt;
   logic [TMR_W-1:0]                      r_timer;
   logic [NUM_FEATURES*FP_TOTAL_BITS-1:0] r_x;
   logic [LABEL_W-1:0]                    r_label;
   logic                                  r_last;
   logic [LABEL_W-1:0]                    r_pred_class;
   logic                                  r_pred_correct, r_pred_timeout;
   logic [CNT_W-1:0]                      r_sample_count, r_correct_count;
   logic                                  r_batch_done;
   logic [CNT_W-1:0]                      w_cnt_nxt;
   logic                                  w_s_ready, w_accept, w_load, w_step, w_timeout, w_finish;
   logic                                  w_mlp_clear, w_mlp_start, w_pred_valid;
   logic                                  w_am_busy, w_am_last;
   logic [LABEL_W-1:0]                    w_am_best;

   mlp_argmax_seq #(
      .NUM_CLASSES   (NUM_CLASSES),
      .FP_TOTAL_BITS (FP_TOTAL_BITS),
      .LABEL_W       (LABEL_W)
   ) u_argmax (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_load),
      .i_step   (w_step),
      .i_scores (mlp_out),
      .o_busy   (w_am_busy),
      .o_last   (w_am_last),
      .o_best   (w_am_best)
   );

   // Next state and strobes; batch_clear overrides everything and aborts the sample
   always_comb begin
      w_state_nxt  = r_state;
      w_s_ready    = 1'b0;
      w_accept     = 1'b0;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_timeout    = 1'b0;
      w_finish     = 1'b0;
      w_mlp_clear  = 1'b0;
      w_mlp_start  = 1'b0;
      w_pred_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_s_ready = !reset && !r_batch_done && !batch_clear;
            w_accept  = w_s_ready && s_if.s_valid;
            if (w_accept) w_state_nxt = CLEAR;
         end
         CLEAR: begin
            w_mlp_clear = 1'b1;
            w_state_nxt = START;
         end
         START: begin
            w_mlp_start = 1'b1;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            if (mlp_done) begin
               w_load      = 1'b1;
               w_state_nxt = SCORE;
            end else if (TMO_EN && (r_timer == TMR_LAST)) begin
               w_timeout   = 1'b1;
               w_state_nxt = REPORT;
            end
         end
         SCORE: begin
            w_step = w_am_busy;
            if (w_am_busy && w_am_last) begin
               w_finish    = 1'b1;
               w_state_nxt = REPORT;
            end
         end
         REPORT: begin
            w_pred_valid = 1'b1;
            w_state_nxt  = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (batch_clear) begin
         w_state_nxt  = IDLE;
         w_load       = 1'b0;
         w_step       = 1'b0;
         w_timeout    = 1'b0;
         w_finish     = 1'b0;
         w_mlp_start  = 1'b0;
         w_pred_valid = 1'b0;
         // the MLP may be mid-computation, so reset it as well
         if (r_state inside {START, WAIT, SCORE}) w_mlp_clear = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Done timer: zeroed while starting the MLP, counts every WAIT cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                r_timer <= '0;
      else if (r_state == START) r_timer <= '0;
      else if (r_state == WAIT)  r_timer <= r_timer + TMR_W'(1);
   end

   // Sample capture on handshake; features stay on mlp_x until the next accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x     <= '0;
         r_label <= '0;
         r_last  <= 1'b0;
      end else if (w_accept) begin
         r_x     <= s_if.s_x;
         r_label <= s_if.s_label;
         r_last  <= s_if.s_last;
      end
   end

   // Prediction result, loaded on entry to REPORT and held until the next one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pred_class   <= '0;
         r_pred_correct <= 1'b0;
         r_pred_timeout <= 1'b0;
      end else if (w_finish) begin
         r_pred_class   <= w_am_best;
         r_pred_correct <= (w_am_best == r_label);
         r_pred_timeout <= 1'b0;
      end else if (w_timeout) begin
         r_pred_class   <= '0;
         r_pred_correct <= 1'b0;
         r_pred_timeout <= 1'b1;
      end
   end

   assign w_cnt_nxt = r_sample_count + CNT_W'(1);

   // Batch counters and sticky batch_done; batch_done blocks intake, so counts cannot pass BATCH_SIZE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sample_count  <= '0;
         r_correct_count <= '0;
         r_batch_done    <= 1'b0;
      end else if (batch_clear) begin
         r_sample_count  <= '0;
         r_correct_count <= '0;
         r_batch_done    <= 1'b0;
      end else if (w_pred_valid) begin
         r_sample_count  <= w_cnt_nxt;
         r_correct_count <= r_correct_count + CNT_W'(r_pred_correct);
         if ((w_cnt_nxt == CNT_W'(BATCH_SIZE)) || r_last) r_batch_done <= 1'b1;
      end
   end

   assign s_if.s_ready  = w_s_ready;
   assign mlp_clear     = w_mlp_clear;
   assign mlp_start     = w_mlp_start;
   assign mlp_x         = r_x;
   assign pred_valid    = w_pred_valid;
   assign pred_class    = r_pred_class;
   assign pred_correct  = r_pred_correct;
   assign pred_timeout  = r_pred_timeout;
   assign sample_count  = r_sample_count;
   assign correct_count = r_correct_count;
   assign batch_done    = r_batch_done;
endmodule
